// File: rtl/sprite_commit_ctrl.sv
// Sprite position/visibility register block with vsync-synchronous commit of a shadow set.
// Optional commit-done interrupt is built only when SPRITE_COMMIT_IRQ_EN is defined.
module sprite_commit_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        write,
  input  logic [8:0]  address,
  input  logic [31:0] writedata,
  input  logic        vga_vs,
  output logic [49:0] spr_x,
  output logic [49:0] spr_y,
  output logic [4:0]  vis_mask,
  output logic [1:0]  anim_sel,
  output logic        commit_pending,
  output logic        irq
);

  typedef enum logic {IDLE, ARMED} state_t;

  // Sprite i occupies bits [10i+9:10i]; order is x0/y0 (dino) up to x4/y4 (godzilla).
  localparam logic [49:0] RST_X      = {10'd100, 10'd500, 10'd300, 10'd200, 10'd100};
  localparam logic [49:0] RST_Y      = {10'd260, 10'd100, 10'd200, 10'd150, 10'd100};
  localparam logic [4:0]  RST_MASK   = 5'b11111;
  localparam logic [5:0]  RST_PERIOD = 6'd6;

  state_t      state_q, state_d;
  logic [49:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [49:0] act_x_q, act_x_d, act_y_q, act_y_d;
  logic [4:0]  sh_mask_q, sh_mask_d, act_mask_q, act_mask_d;
  logic [5:0]  period_q, period_d, cnt_q, cnt_d;
  logic [1:0]  anim_q, anim_d;
  logic        vs_d_q, vs_d_d;

  logic wr_en, ctrl_wr, fall, commit;
  logic unused_wdata;

  assign unused_wdata = ^writedata[31:10];

  // NOTE: every _d gets its hold value first, so no path through this block can infer a latch.
  always_comb begin
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_mask_d  = sh_mask_q;
    act_x_d    = act_x_q;
    act_y_d    = act_y_q;
    act_mask_d = act_mask_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    anim_d     = anim_q;
    state_d    = state_q;
    vs_d_d     = vga_vs;

    wr_en   = chipselect & write;
    ctrl_wr = wr_en && (address == 9'd12);
    fall    = vs_d_q & ~vga_vs;
    commit  = (state_q == ARMED) && fall;

    for (int i = 0; i < 5; i++) begin
      if (wr_en && address == 9'(2 * i))     sh_x_d[10*i +: 10] = writedata[9:0];
      if (wr_en && address == 9'(2 * i + 1)) sh_y_d[10*i +: 10] = writedata[9:0];
    end
    if (wr_en && address == 9'd10) sh_mask_d = writedata[4:0];

    // Commit copies the registered shadow, so a coincident shadow write waits for the next commit.
    if (commit) begin
      act_x_d    = sh_x_q;
      act_y_d    = sh_y_q;
      act_mask_d = sh_mask_q;
      state_d    = IDLE;
    end else if (ctrl_wr && writedata[0]) begin
      state_d = ARMED;
    end

    if (wr_en && address == 9'd11) begin
      period_d = writedata[5:0];
      cnt_d    = '0;
    end else if (fall && period_q != 6'd0) begin
      if (cnt_q == period_q - 6'd1) begin
        cnt_d  = '0;
        anim_d = (anim_q == 2'd2) ? 2'd0 : anim_q + 2'd1;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values together.
  // NOTE: the shadow set is plain flops, not a RAM, so it takes reset values like any register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      sh_x_q     <= RST_X;
      sh_y_q     <= RST_Y;
      sh_mask_q  <= RST_MASK;
      act_x_q    <= RST_X;
      act_y_q    <= RST_Y;
      act_mask_q <= RST_MASK;
      period_q   <= RST_PERIOD;
      cnt_q      <= '0;
      anim_q     <= 2'd0;
      vs_d_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      sh_x_q     <= sh_x_d;
      sh_y_q     <= sh_y_d;
      sh_mask_q  <= sh_mask_d;
      act_x_q    <= act_x_d;
      act_y_q    <= act_y_d;
      act_mask_q <= act_mask_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      anim_q     <= anim_d;
      vs_d_q     <= vs_d_d;
    end
  end

`ifdef SPRITE_COMMIT_IRQ_EN
  logic irq_q, irq_d;

  // Set wins over a coincident acknowledge.
  always_comb begin
    irq_d = irq_q;
    if (ctrl_wr && writedata[1]) irq_d = 1'b0;
    if (commit)                  irq_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq_q <= 1'b0;
    else          irq_q <= irq_d;
  end

  assign irq = irq_q;
`else
  assign irq = 1'b0;
`endif

  assign spr_x          = act_x_q;
  assign spr_y          = act_y_q;
  assign vis_mask       = act_mask_q;
  assign anim_sel       = anim_q;
  assign commit_pending = (state_q == ARMED);

endmodule

// File: tb/tb_sprite_commit_ctrl.sv
// Directed bench for sprite_commit_ctrl: drives bus writes and vsync falls, checks outputs
// 1 ns after each rising edge through a single check() task.
module tb_sprite_commit_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        chipselect, write, vga_vs;
  logic [8:0]  address;
  logic [31:0] writedata;
  logic [49:0] spr_x, spr_y;
  logic [4:0]  vis_mask;
  logic [1:0]  anim_sel;
  logic        commit_pending, irq;

  int cyc      = 0;
  int n_checks = 0;
  int n_errors = 0;

`ifdef SPRITE_COMMIT_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  localparam logic [49:0] RST_X = {10'd100, 10'd500, 10'd300, 10'd200, 10'd100};
  localparam logic [49:0] RST_Y = {10'd260, 10'd100, 10'd200, 10'd150, 10'd100};

  sprite_commit_ctrl dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .chipselect     (chipselect),
    .write          (write),
    .address        (address),
    .writedata      (writedata),
    .vga_vs         (vga_vs),
    .spr_x          (spr_x),
    .spr_y          (spr_y),
    .vis_mask       (vis_mask),
    .anim_sel       (anim_sel),
    .commit_pending (commit_pending),
    .irq            (irq)
  );

  always #10 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(string name, logic [49:0] got, logic [49:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write      = 1'b0;
    vga_vs     = 1'b1;
  endtask

  task automatic wr(logic [8:0] a, logic [31:0] d);
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
    step();
  endtask

  // One idle cycle so vs_d is high, then a cycle where vsync falls (optionally with a bus write).
  task automatic fall_edge(logic do_wr, logic [8:0] a, logic [31:0] d);
    step();
    if (do_wr) begin
      chipselect = 1'b1;
      write      = 1'b1;
      address    = a;
      writedata  = d;
    end
    vga_vs = 1'b0;
    step();
  endtask

  task automatic do_reset();
    #3 reset_n = 1'b0;
    @(posedge clk);
    #5 reset_n = 1'b1;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] anim_seq [7];
    anim_seq = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd0, 2'd0};

    reset_n = 1'b0; chipselect = 1'b0; write = 1'b0; vga_vs = 1'b1;
    address = '0;   writedata = '0;
    #25 reset_n = 1'b1;
    step();

    // Reset state.
    check("x0",   50'(spr_x[9:0]),     100);
    check("y4",   50'(spr_y[49:40]),   260);
    check("mask", 50'(vis_mask),       5'h1F);
    check("anim", 50'(anim_sel),       0);
    check("pend", 50'(commit_pending), 0);
    check("irq",  50'(irq),            0);
    check("sprx", spr_x,               RST_X);
    check("spry", spr_y,               RST_Y);

    // Shadow writes stay invisible until a commit.
    wr(9'd0, 32'd320);
    wr(9'd10, 32'h01);
    check("x0",   50'(spr_x[9:0]), 100);
    check("mask", 50'(vis_mask),   5'h1F);
    for (int i = 0; i < 3; i++) begin
      fall_edge(1'b0, '0, '0);
      check("x0", 50'(spr_x[9:0]), 100);
    end
    wr(9'd12, 32'd1);
    check("pend", 50'(commit_pending), 1);
    check("x0",   50'(spr_x[9:0]),     100);
    fall_edge(1'b0, '0, '0);
    check("x0",   50'(spr_x[9:0]),     320);
    check("mask", 50'(vis_mask),       5'h01);
    check("pend", 50'(commit_pending), 0);

    // Arm coincident with fall in IDLE; shadow write coincident with the commit fall.
    wr(9'd0, 32'd50);
    fall_edge(1'b1, 9'd12, 32'd1);
    check("pend", 50'(commit_pending), 1);
    check("x0",   50'(spr_x[9:0]),     320);
    fall_edge(1'b1, 9'd0, 32'd77);
    check("x0",   50'(spr_x[9:0]),     50);
    check("pend", 50'(commit_pending), 0);
    wr(9'd12, 32'd1);
    fall_edge(1'b0, '0, '0);
    check("x0", 50'(spr_x[9:0]), 77);

    // Re-arm while armed is harmless; arm coincident with fall while armed commits once.
    wr(9'd9, 32'd123);
    wr(9'd12, 32'd1);
    wr(9'd12, 32'd1);
    check("pend", 50'(commit_pending), 1);
    check("y4",   50'(spr_y[49:40]),   260);
    fall_edge(1'b1, 9'd12, 32'd1);
    check("y4",   50'(spr_y[49:40]),   123);
    check("pend", 50'(commit_pending), 0);
    fall_edge(1'b0, '0, '0);
    check("pend", 50'(commit_pending), 0);
    check("y4",   50'(spr_y[49:40]),   123);

    // Animation with period 2, then a coincident period write, then period 0 freezes.
    do_reset();
    wr(9'd11, 32'd2);
    check("anim", 50'(anim_sel), 0);
    for (int i = 0; i < 7; i++) begin
      fall_edge(1'b0, '0, '0);
      check("anim", 50'(anim_sel), 50'(anim_seq[i]));
    end
    fall_edge(1'b1, 9'd11, 32'd2);
    check("anim", 50'(anim_sel), 0);
    fall_edge(1'b0, '0, '0);
    check("anim", 50'(anim_sel), 0);
    fall_edge(1'b0, '0, '0);
    check("anim", 50'(anim_sel), 1);
    wr(9'd11, 32'd0);
    for (int i = 0; i < 5; i++) begin
      fall_edge(1'b0, '0, '0);
      check("anim", 50'(anim_sel), 1);
    end

    // Interrupt set, acknowledge, and set-over-clear with combined control bits.
    wr(9'd12, 32'd1);
    fall_edge(1'b0, '0, '0);
    check("irq",  50'(irq),            50'(IRQ_ON));
    check("pend", 50'(commit_pending), 0);
    wr(9'd12, 32'd2);
    check("irq",  50'(irq),            0);
    wr(9'd12, 32'd1);
    check("pend", 50'(commit_pending), 1);
    check("irq",  50'(irq),            0);
    fall_edge(1'b1, 9'd12, 32'd3);
    check("irq",  50'(irq),            50'(IRQ_ON));
    check("pend", 50'(commit_pending), 0);

    // Asynchronous reset while armed: immediate return to reset values, no later commit.
    wr(9'd0, 32'd444);
    wr(9'd12, 32'd1);
    check("pend", 50'(commit_pending), 1);
    #4 reset_n = 1'b0;
    #1;
    check("x0",   50'(spr_x[9:0]),     100);
    check("pend", 50'(commit_pending), 0);
    check("mask", 50'(vis_mask),       5'h1F);
    check("anim", 50'(anim_sel),       0);
    check("irq",  50'(irq),            0);
    check("sprx", spr_x,               RST_X);
    check("spry", spr_y,               RST_Y);
    @(posedge clk);
    #5 reset_n = 1'b1;
    fall_edge(1'b0, '0, '0);
    check("x0",   50'(spr_x[9:0]),     100);
    check("pend", 50'(commit_pending), 0);
    wr(9'd12, 32'd1);
    fall_edge(1'b0, '0, '0);
    check("x0",   50'(spr_x[9:0]),     100);
    check("pend", 50'(commit_pending), 0);

    step();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
